// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the stage buffers.
// Provides IF/ID payload geometry and the bubble (NOP) value.
package pipe_pkg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int IFID_W = PC_W + INST_W;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  localparam logic [IFID_W-1:0] IFID_BUBBLE =
    {{PC_W{1'b0}}, NOP_INST};

  typedef struct packed {
    logic [PC_W-1:0]   pc4;
    logic [INST_W-1:0] inst;
  } if_id_t;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between a stage buffer and its neighbours.
// master = surrounding pipeline/hazard logic, slave = the buffer.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 64
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/pipe_slot.sv
// One payload register of a stage buffer: load, or clear to CLR_VAL.
// Ports: clock, resetn (sync, low), load_i, clear_i, d_i, q_o.
module pipe_slot #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clock) begin
    if (!resetn || clear_i) begin
      data_q <= CLR_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready, optional skid, flush.
// Ports: clock, resetn (sync, low), bus (slave): in_*/out_*/flush/count.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = IFID_W,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] FLUSH_VAL = DATA_W'(IFID_BUBBLE)
) (
  input  logic             clock,
  input  logic             resetn,
  pipe_stage_buf_if.slave  bus
);

  logic [1:0]        count_q, count_d;
  logic              rdy_q, rdy_d;
  logic              in_ready;
  logic              out_valid;
  logic              push, pop;
  logic              main_ld, main_clr;
  logic              skid_ld, skid_clr;
  logic [DATA_W-1:0] main_d, main_q, skid_q;

  assign out_valid = (count_q != 2'd0);

  // DEPTH=1 passes out_ready straight through; DEPTH=2 cuts that path.
  assign in_ready = (DEPTH == 1)
                  ? (!out_valid | bus.out_ready)
                  : rdy_q;

  assign push = bus.in_valid & in_ready & !bus.flush;
  assign pop  = out_valid & bus.out_ready;

  always_comb begin
    count_d  = count_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    main_d   = bus.in_data;
    if (bus.flush) begin
      count_d  = 2'd0;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (push && pop) begin
      // Only reachable with one entry held: replace it.
      main_ld = 1'b1;
    end else if (push) begin
      count_d = count_q + 2'd1;
      if (count_q == 2'd0) begin
        main_ld = 1'b1;
      end else begin
        skid_ld = 1'b1;
      end
    end else if (pop) begin
      count_d = count_q - 2'd1;
      if (count_q == 2'd2) begin
        main_ld  = 1'b1;
        main_d   = skid_q;
        skid_clr = 1'b1;
      end else begin
        main_clr = 1'b1;
      end
    end
    rdy_d = (count_d != 2'd2);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= 2'd0;
      rdy_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      rdy_q   <= rdy_d;
    end
  end

  pipe_slot #(
    .DATA_W  (DATA_W),
    .CLR_VAL (FLUSH_VAL)
  ) u_main (
    .clock   (clock),
    .resetn  (resetn),
    .load_i  (main_ld),
    .clear_i (main_clr),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  if (DEPTH == 2) begin : g_skid
    pipe_slot #(
      .DATA_W  (DATA_W),
      .CLR_VAL (FLUSH_VAL)
    ) u_skid (
      .clock   (clock),
      .resetn  (resetn),
      .load_i  (skid_ld),
      .clear_i (skid_clr),
      .d_i     (bus.in_data),
      .q_o     (skid_q)
    );
  end else begin : g_noskid
    logic unused_skid;
    assign unused_skid = skid_ld ^ skid_clr;
    assign skid_q      = FLUSH_VAL;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  // Gate the payload so nothing stale is ever visible as a bubble.
  assign bus.out_data  = out_valid ? main_q : FLUSH_VAL;
  assign bus.count     = count_q;

endmodule
